// File: rtl/comb_pkg.sv
// Shared definitions for the combination calculator: widths, FSM states, helpers.
package comb_pkg;

  localparam int IN_W  = 4;
  localparam int ANS_W = 15;
  localparam int ROWS  = 1 << IN_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOADN  = 3'd1,
    INIT   = 3'd2,
    UPDATE = 3'd3,
    FINISH = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Unsigned minimum of two operand-width values.
  function automatic logic [IN_W-1:0] min_op(input logic [IN_W-1:0] a,
                                             input logic [IN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/comb_row_file.sv
// One row of Pascal's triangle held as a 16-entry register array.
// Supports clear-to-unit-row, in-place accumulate row[k] += row[k-1],
// and a combinational read port.
module comb_row_file
  import comb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             acc,
  input  logic [IN_W-1:0]  k,
  input  logic [IN_W-1:0]  rd_idx,
  output logic [ANS_W-1:0] rd_data
);

  logic [ANS_W-1:0] row [ROWS];

  // Row storage: clear to {1,0,0,...} or accumulate one entry per cycle.
  // NOTE: the array is reset explicitly so no entry ever reads as X, even
  // though INIT also clears it before every computation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) row[i] <= '0;
    end else if (clear) begin
      row[0] <= ANS_W'(1);
      for (int i = 1; i < ROWS; i++) row[i] <= '0;
    end else if (acc) begin
      // k is always >= 1 while accumulating, so k-1 never wraps.
      row[k] <= row[k] + row[k - IN_W'(1)];
    end
  end

  assign rd_data = row[rd_idx];

endmodule

// File: rtl/comb_toplevel.sv
// Sequential combination calculator: answer = C(N,M).
// N then M arrive on a shared bus framed by start; Pascal's triangle is
// built in place one addition per cycle, and the result is held with Done.
module comb_toplevel
  import comb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  N,
  output logic             Done,
  output logic [ANS_W-1:0] answer
);

  state_t          state;
  logic [IN_W-1:0] n_reg;
  logic [IN_W-1:0] m_reg;
  logic [IN_W-1:0] r;
  logic [IN_W-1:0] k;
  logic [ANS_W-1:0] rd_data;

  comb_row_file u_row (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == INIT),
    .acc     (state == UPDATE),
    .k       (k),
    .rd_idx  (m_reg),
    .rd_data (rd_data)
  );

  // Control FSM: operand capture, row sweep sequencing and registered outputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // branch sees the pre-edge values of r, k and the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      Done   <= 1'b0;
      answer <= '0;
      n_reg  <= '0;
      m_reg  <= '0;
      r      <= '0;
      k      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_reg <= N;
            state <= LOADN;
          end
        end
        LOADN: begin
          // While start stays high the latest N wins; the falling cycle carries M.
          if (start) begin
            n_reg <= N;
          end else begin
            m_reg <= N;
            state <= INIT;
          end
        end
        INIT: begin
          r     <= IN_W'(1);
          k     <= min_op(IN_W'(1), m_reg);
          state <= (n_reg == '0 || m_reg == '0) ? FINISH : UPDATE;
        end
        UPDATE: begin
          // k walks downward so row[k-1] still holds the previous row's value.
          if (k == IN_W'(1)) begin
            if (r == n_reg) begin
              state <= FINISH;
            end else begin
              r <= r + IN_W'(1);
              k <= min_op(r + IN_W'(1), m_reg);
            end
          end else begin
            k <= k - IN_W'(1);
          end
        end
        FINISH: begin
          // Entries above the last built row are still 0, so M>N yields 0.
          answer <= rd_data;
          Done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          if (start) begin
            Done  <= 1'b0;
            n_reg <= N;
            state <= LOADN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_toplevel.sv
// Self-checking bench for comb_toplevel: directed edge cases plus random
// requests compared against an arithmetic binomial / latency model.
module tb_comb_toplevel;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  N;
  logic        Done;
  logic [14:0] answer;

  int checks   = 0;
  int failures = 0;

  comb_toplevel dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .N      (N),
    .Done   (Done),
    .answer (answer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint binom(input int n, input int m);
    longint res = 1;
    if (m > n) return 0;
    for (int i = 1; i <= m; i++) res = res * (n - m + i) / i;
    return res;
  endfunction

  function automatic int latency(input int n, input int m);
    int s = 2;
    for (int i = 1; i <= n; i++) s += (i < m) ? i : m;
    return s;
  endfunction

  // Wait for Done after the start-fall edge; optionally jiggle the inputs
  // while the computation runs. Checks result and cycle count.
  task automatic finish_req(input string tag, input int n, input int m, input bit perturb);
    int cnt = 0;
    while (!Done && cnt < 300) begin
      step();
      cnt++;
      if (perturb && !Done) begin
        start = 1'($urandom_range(0, 1));
        N     = 4'($urandom_range(0, 15));
      end
    end
    start = 1'b0;
    check({tag, "_done"}, Done, 1);
    check({tag, "_answer"}, answer, binom(n, m));
    check({tag, "_latency"}, cnt, latency(n, m));
  endtask

  task automatic run_req(input string tag, input int n, input int m, input bit perturb);
    start = 1'b1;
    N     = 4'(n);
    step();
    check({tag, "_done_low"}, Done, 0);
    start = 1'b0;
    N     = 4'(m);
    step();
    finish_req(tag, n, m, perturb);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    N     = '0;
    step();
    step();
    check("reset_done", Done, 0);
    check("reset_answer", answer, 0);
    rst = 1'b0;
    step();
    check("idle_done", Done, 0);

    // Basic and directed requests; each one's start drops the previous Done.
    run_req("c5_3", 5, 3, 1'b0);
    run_req("c8_2", 8, 2, 1'b0);
    run_req("c6_3", 6, 3, 1'b0);
    run_req("c15_7", 15, 7, 1'b0);
    run_req("c4_0", 4, 0, 1'b0);
    run_req("c0_0", 0, 0, 1'b0);
    run_req("c3_5", 3, 5, 1'b0);
    run_req("c15_15", 15, 15, 1'b0);

    // Inputs toggling during the computation must be ignored.
    run_req("perturb_9_4", 9, 4, 1'b1);
    run_req("perturb_12_6", 12, 6, 1'b1);

    // start held high with N changing: last N before the fall is used.
    start = 1'b1;
    N     = 4'd2;
    step();
    check("hold_done_low", Done, 0);
    N = 4'd13;
    step();
    N = 4'd7;
    step();
    N = 4'd10;
    step();
    start = 1'b0;
    N     = 4'd4;
    step();
    finish_req("hold_10_4", 10, 4, 1'b0);

    // Reset in the middle of a sweep clears outputs without a clock edge.
    run_req("pre_rst_6_3", 6, 3, 1'b0);
    start = 1'b1;
    N     = 4'd15;
    step();
    start = 1'b0;
    N     = 4'd7;
    step();
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_done", Done, 0);
    check("midrst_answer", answer, 0);
    step();
    rst = 1'b0;
    step();
    run_req("post_rst_5_3", 5, 3, 1'b0);

    // Random requests against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      int rn = $urandom_range(0, 15);
      int rm = $urandom_range(0, 15);
      run_req($sformatf("rand%0d_%0d_%0d", i, rn, rm), rn, rm, 1'(i % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
